// File: rtl/dds_increment_estimator_if.sv
// Control and result signals of the DDS increment estimator.
// COUNT_WIDTH must match the estimator instance it connects to.
interface dds_increment_estimator_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   enable;
    logic                   marker_in;
    logic [31:0]            increment;
    logic                   increment_valid;
    logic [COUNT_WIDTH-1:0] gate_cycles;
    logic                   busy;
    logic                   timeout;

    modport master (
        output enable, marker_in,
        input  increment, increment_valid, gate_cycles, busy, timeout
    );
    modport slave (
        input  enable, marker_in,
        output increment, increment_valid, gate_cycles, busy, timeout
    );
endinterface

// File: rtl/dds_increment_estimator.sv
// Counts reference cycles across 2^GATE_LOG2 marker periods, then divides
// 2^(32+GATE_LOG2) by that count to give the DDS phase increment.
module dds_increment_estimator #(
    parameter int GATE_LOG2   = 10,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset_in,
    dds_increment_estimator_if.slave  bus
);
    localparam int RW = COUNT_WIDTH + 1;
    localparam int NW = GATE_LOG2 + 1;
    localparam logic [NW-1:0] LAST_EDGE = NW'((1 << GATE_LOG2) - 1);
    localparam logic [RW-1:0] REM_INIT  = RW'(1) << GATE_LOG2;
    localparam logic [31:0]   INC_RESET = 32'h3333_3333;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_COUNT,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic                   enable_prev_q;
    logic [COUNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [NW-1:0]          nedge_q, nedge_d;
    logic [COUNT_WIDTH-1:0] gate_q, gate_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [31:0]            quot_q, quot_d;
    logic [4:0]             iter_q, iter_d;
    logic [31:0]            inc_q, inc_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic                   marker_edge;
    logic                   en_rise;
    logic [RW:0]            rem_dbl;
    logic [RW:0]            div_ext;
    logic                   fits;

    assign marker_edge = sync2_q & ~prev_q;
    assign en_rise     = bus.enable & ~enable_prev_q;

    // Remainder stays below the divisor, so doubling needs only one extra bit.
    assign rem_dbl = {rem_q, 1'b0};
    assign div_ext = {2'b00, gate_q};
    assign fits    = (rem_dbl >= div_ext);

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d   = state_q;
        cyc_d     = cyc_q;
        nedge_d   = nedge_q;
        gate_d    = gate_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        iter_d    = iter_q;
        inc_d     = inc_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q & ~en_rise;

        if (state_q != S_IDLE && !bus.enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.enable) state_d = S_ARM;
                end
                S_ARM: begin
                    if (marker_edge) begin
                        cyc_d   = '0;
                        nedge_d = '0;
                        state_d = S_COUNT;
                    end
                end
                S_COUNT: begin
                    cyc_d = cyc_q + COUNT_WIDTH'(1);
                    if (marker_edge) nedge_d = nedge_q + NW'(1);
                    if (&cyc_q) begin
                        timeout_d = 1'b1;
                        state_d   = S_ARM;
                    end else if (marker_edge && nedge_q == LAST_EDGE) begin
                        gate_d  = cyc_q + COUNT_WIDTH'(1);
                        rem_d   = REM_INIT;
                        quot_d  = '0;
                        iter_d  = '0;
                        state_d = S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_d  = fits ? RW'(rem_dbl - div_ext) : RW'(rem_dbl);
                    quot_d = {quot_q[30:0], fits};
                    iter_d = iter_q + 5'd1;
                    if (&iter_q) state_d = S_DONE;
                end
                S_DONE: begin
                    inc_d   = quot_q;
                    valid_d = 1'b1;
                    state_d = S_ARM;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            enable_prev_q <= 1'b0;
            cyc_q         <= '0;
            nedge_q       <= '0;
            gate_q        <= '0;
            rem_q         <= '0;
            quot_q        <= '0;
            iter_q        <= '0;
            inc_q         <= INC_RESET;
            valid_q       <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= bus.marker_in;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            enable_prev_q <= bus.enable;
            cyc_q         <= cyc_d;
            nedge_q       <= nedge_d;
            gate_q        <= gate_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            iter_q        <= iter_d;
            inc_q         <= inc_d;
            valid_q       <= valid_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bus.increment       = inc_q;
    assign bus.increment_valid = valid_q;
    assign bus.gate_cycles     = gate_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.timeout         = timeout_q;
endmodule
